// File: rtl/vmask_cpop_if.sv
// Channel bundle between the mask-popcount sequencer and its environment:
// request, mask-byte source, popcount datapath and response.
interface vmask_cpop_if #(
  parameter int MASK_W = 8,
  parameter int DATA_W = 64,
  parameter int VL_W   = 11
);
  // Every channel uses valid/ready: a transfer happens on a rising clk edge
  // where both are high; a producer holds valid and its payload stable until
  // that edge, and valid never depends on ready.
  logic              req_valid;
  logic              req_ready;
  logic [VL_W-1:0]   req_vl;
  logic              src_valid;
  logic              src_ready;
  logic [MASK_W-1:0] src_mask;
  logic              dp_valid;
  logic [MASK_W-1:0] dp_m0;
  logic [DATA_W-1:0] dp_count;
  logic [MASK_W-1:0] dp_res;
  logic              resp_valid;
  logic              resp_ready;
  logic [VL_W-1:0]   resp_count;
  logic              busy;

  modport master (
    output req_valid, req_vl, src_valid, src_mask, dp_res, resp_ready,
    input  req_ready, src_ready, dp_valid, dp_m0, dp_count, resp_valid,
           resp_count, busy
  );

  modport slave (
    input  req_valid, req_vl, src_valid, src_mask, dp_res, resp_ready,
    output req_ready, src_ready, dp_valid, dp_m0, dp_count, resp_valid,
           resp_count, busy
  );
endinterface

// File: rtl/vmask_cpop_seq.sv
// Sequencer for the 3-stage mask popcount datapath: streams tail-masked mask
// bytes into the datapath, sums the per-beat counts and returns one total.
module vmask_cpop_seq #(
  parameter int MASK_W = 8,
  parameter int DATA_W = 64,
  parameter int VL_W   = 11,
  parameter int LAT    = 3
) (
  input  logic       clk,
  input  logic       rst,
  vmask_cpop_if.slave bus,
  output logic [1:0] fsm_state
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  localparam logic [VL_W-1:0] MW = VL_W'(MASK_W);

  state_t            state, state_nx;
  logic [VL_W-1:0]   rem;
  logic [VL_W-1:0]   acc;
  logic [LAT-1:0]    tag;
  logic [LAT-1:0]    tag_nx;
  logic [MASK_W-1:0] tmask;
  logic              beat;
  logic              last_beat;

  always_comb begin
    tmask = '1;
    if (rem < MW) begin
      for (int i = 0; i < MASK_W; i++) begin
        tmask[i] = (VL_W'(i) < rem);
      end
    end
  end

  assign beat      = (state == ISSUE) && bus.src_valid;
  assign last_beat = (rem <= MW);
  assign tag_nx    = {tag[LAT-2:0], beat};

  assign bus.req_ready  = (state == IDLE);
  assign bus.src_ready  = (state == ISSUE);
  assign bus.dp_valid   = beat;
  assign bus.dp_m0      = beat ? (bus.src_mask & tmask) : '0;
  assign bus.dp_count   = '0;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_count = (state == RESP) ? acc : '0;
  assign bus.busy       = (state != IDLE);
  assign fsm_state      = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_nx = (bus.req_vl == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (beat && last_beat) begin
          state_nx = DRAIN;
        end
      end
      // Leave once the only beat still in flight is the one accumulating
      // this cycle, so the total is ready the cycle RESP is entered.
      DRAIN: begin
        if (tag_nx == '0) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tag   <= '0;
      rem   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nx;
      tag   <= tag_nx;
      if ((state == IDLE) && bus.req_valid) begin
        rem <= bus.req_vl;
        acc <= '0;
      end else begin
        if (beat) begin
          rem <= last_beat ? '0 : (rem - MW);
        end
        if (tag[LAT-1]) begin
          acc <= acc + VL_W'(bus.dp_res);
        end
      end
    end
  end
endmodule

// File: tb/tb_vmask_cpop_seq.sv
// Directed bench for vmask_cpop_seq with a popcount datapath model and a
// per-cycle scoreboard of issued mask bytes and returned counts.
module tb_vmask_cpop_seq;
  localparam int MASK_W = 8;
  localparam int DATA_W = 64;
  localparam int VL_W   = 11;
  localparam int LAT    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] fsm_state;

  vmask_cpop_if #(.MASK_W(MASK_W), .DATA_W(DATA_W), .VL_W(VL_W)) bus ();

  vmask_cpop_seq #(.MASK_W(MASK_W), .DATA_W(DATA_W), .VL_W(VL_W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  // ---------------- datapath model ----------------
  // Popcount of each issued byte appears LAT cycles later; idle stages
  // present a nonzero junk value that must never be accumulated.
  logic [LAT-1:0]    pv;
  logic [MASK_W-1:0] pd [LAT];

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], bus.dp_valid};
      pd[0] <= MASK_W'($countones(bus.dp_m0));
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end

  assign bus.dp_res = pv[LAT-1] ? pd[LAT-1] : MASK_W'(7);

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [MASK_W-1:0] exp_q[$];
  logic [VL_W-1:0]   cnt_q[$];
  int dp_pulses  = 0;
  int src_cycles = 0;
  bit run_chk    = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (run_chk && !rst) begin
      if (bus.src_ready) src_cycles++;
      if (bus.dp_valid) begin
        dp_pulses++;
        check("dp_count", int'(bus.dp_count != '0), 0);
        if (exp_q.size() == 0) check("dp_unexpected", 1, 0);
        else check("dp_m0", int'(bus.dp_m0), int'(exp_q.pop_front()));
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (cnt_q.size() == 0) check("resp_unexpected", 1, 0);
        else check("resp_count", int'(bus.resp_count), int'(cnt_q.pop_front()));
      end
      check("busy_vs_req_ready", int'(bus.busy), int'(!bus.req_ready));
    end
  end

  // ---------------- driver ----------------
  logic [MASK_W-1:0] masks [4];
  int obs_m [4];
  int resp_cyc;
  int resp_val;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One job: beats from masks[], gap idle source cycles before each beat
  // after the first, response held off for hold cycles.
  task automatic run_job(input int vl, input int gap, input int hold);
    int nb, t0, budget, left, exp_cnt;
    logic [MASK_W-1:0] tm, m;
    nb = (vl + MASK_W - 1) / MASK_W;
    exp_cnt = 0;
    for (int k = 0; k < nb; k++) begin
      left = vl - MASK_W * k;
      tm = (left >= MASK_W) ? '1 : MASK_W'((1 << left) - 1);
      m = masks[k] & tm;
      exp_q.push_back(m);
      exp_cnt += $countones(m);
    end
    cnt_q.push_back(VL_W'(exp_cnt));
    for (int k = 0; k < 4; k++) obs_m[k] = -1;
    resp_cyc = -1;
    resp_val = -1;

    bus.req_valid = 1'b1;
    bus.req_vl    = VL_W'(vl);
    t0 = cyc;
    tick();
    bus.req_valid = 1'b0;
    bus.req_vl    = '0;

    for (int k = 0; k < nb; k++) begin
      if (k > 0) repeat (gap) tick();
      bus.src_valid = 1'b1;
      bus.src_mask  = masks[k];
      #1;
      budget = 0;
      while (!bus.src_ready && budget < 20) begin
        tick();
        budget++;
      end
      check("src_ready_wait", int'(bus.src_ready), 1);
      obs_m[k] = int'(bus.dp_m0);
      tick();
      bus.src_valid = 1'b0;
      bus.src_mask  = '0;
    end

    bus.resp_ready = (hold == 0);
    budget = 0;
    while (!bus.resp_valid && budget < 50) begin
      tick();
      budget++;
    end
    check("resp_valid_wait", int'(bus.resp_valid), 1);
    resp_cyc = cyc - t0;
    resp_val = int'(bus.resp_count);

    for (int h = 0; h < hold; h++) begin
      check("hold_resp_valid", int'(bus.resp_valid), 1);
      check("hold_resp_count", int'(bus.resp_count), resp_val);
      check("hold_req_ready", int'(bus.req_ready), 0);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("idle_after_resp", int'(fsm_state), 0);
    check("req_ready_after_resp", int'(bus.req_ready), 1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  int p0, s0;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_vl     = '0;
    bus.src_valid  = 1'b0;
    bus.src_mask   = '0;
    bus.resp_ready = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", int'(bus.req_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_src_ready", int'(bus.src_ready), 0);
    check("rst_dp_valid", int'(bus.dp_valid), 0);
    check("rst_resp_valid", int'(bus.resp_valid), 0);
    check("rst_resp_count", int'(bus.resp_count), 0);
    rst = 1'b0;
    run_chk = 1'b1;
    tick();

    // basic count
    masks[0] = 8'hFF; masks[1] = 8'h0F;
    run_job(16, 0, 0);
    check("basic_m0_beat1", obs_m[0], 'hFF);
    check("basic_m0_beat2", obs_m[1], 'h0F);
    check("basic_resp_cycle", resp_cyc, 6);
    check("basic_count", resp_val, 12);

    // tail masking
    masks[0] = 8'hFF; masks[1] = 8'hFF;
    run_job(13, 0, 0);
    check("tail_m0_beat2", obs_m[1], 'h1F);
    check("tail_count", resp_val, 13);
    check("tail_resp_cycle", resp_cyc, 6);

    // empty vector
    p0 = dp_pulses; s0 = src_cycles;
    run_job(0, 0, 0);
    check("empty_dp_pulses", dp_pulses - p0, 0);
    check("empty_src_ready", src_cycles - s0, 0);
    check("empty_resp_cycle", resp_cyc, 1);
    check("empty_count", resp_val, 0);

    // source bubbles
    masks[0] = 8'h01; masks[1] = 8'h03; masks[2] = 8'h07;
    p0 = dp_pulses;
    run_job(24, 2, 0);
    check("bubble_dp_pulses", dp_pulses - p0, 3);
    check("bubble_count", resp_val, 6);
    check("bubble_resp_cycle", resp_cyc, 11);

    // response backpressure
    masks[0] = 8'hAA;
    run_job(8, 0, 5);
    check("bp_count", resp_val, 4);
    check("bp_resp_cycle", resp_cyc, 5);

    // short tails
    masks[0] = 8'hFF;
    run_job(1, 0, 0);
    check("vl1_count", resp_val, 1);
    masks[0] = 8'h00; masks[1] = 8'hFF;
    run_job(11, 0, 0);
    check("vl11_m0_beat2", obs_m[1], 'h07);
    check("vl11_count", resp_val, 3);

    // reset mid-operation
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    bus.req_valid = 1'b1;
    bus.req_vl    = VL_W'(32);
    tick();
    bus.req_valid = 1'b0;
    bus.src_valid = 1'b1;
    bus.src_mask  = 8'hFF;
    tick();
    tick();
    check("pre_rst_in_issue", int'(fsm_state), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_mask  = '0;
    exp_q.delete();
    check("post_rst_state", int'(fsm_state), 0);
    check("post_rst_busy", int'(bus.busy), 0);
    check("post_rst_resp_valid", int'(bus.resp_valid), 0);
    check("post_rst_req_ready", int'(bus.req_ready), 1);
    repeat (4) begin
      tick();
      check("post_rst_no_resp", int'(bus.resp_valid), 0);
    end
    masks[0] = 8'h81;
    run_job(8, 0, 0);
    check("after_rst_count", resp_val, 2);

    repeat (3) tick();
    check("exp_q_drained", exp_q.size(), 0);
    check("cnt_q_drained", cnt_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
